tmds_video_timing_ctrl: RTL and testbench

// Video timing controller/scheduler that sequences the three per-channel TMDS encoders of the HDMI TX.

---
 rtl/tmds_video_timing_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_tmds_video_timing_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_video_timing_ctrl.sv
// rtl/tmds_video_timing_ctrl.sv - video raster timing and TMDS encoder scheduler
//
// Purpose: generates the h/v raster, pulls pixels from an upstream valid/ready
// source during active video and drives the three TMDS encoders with
// registered, mutually aligned data/control/disp_en (1 cycle latency).
//
// Ports:
//   i_clk, i_reset         pixel clock, synchronous active-high reset
//   i_enable               run request, sampled only in PARK and at frame end
//   i_pix_valid/i_pix_data upstream pixel {R,G,B}; o_pix_ready is combinational
//   o_disp_en              1 = data period on all three encoders
//   o_ctrl_b/_g/_r         encoder control; blue carries {vsync,hsync}
//   o_data_r/_g/_b         encoder pixel data
//   o_hcount/o_vcount      raster position of the current output
//   o_frame_start          pulse with the output of position (0,0)
//   o_underflow            sticky, cleared by i_underflow_clr (set wins)
module tmds_video_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_pix_valid,
    input  logic [23:0] i_pix_data,
    input  logic        i_underflow_clr,
    output logic        o_pix_ready,
    output logic        o_disp_en,
    output logic [1:0]  o_ctrl_b,
    output logic [1:0]  o_ctrl_g,
    output logic [1:0]  o_ctrl_r,
    output logic [7:0]  o_data_r,
    output logic [7:0]  o_data_g,
    output logic [7:0]  o_data_b,
    output logic [11:0] o_hcount,
    output logic [11:0] o_vcount,
    output logic        o_frame_start,
    output logic        o_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Thresholds are 13 bits so a sync region ending exactly at 4096 still compares correctly.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        PARK = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_h;
    logic [11:0] r_v;
    logic [11:0] w_h_nxt;
    logic [11:0] w_v_nxt;

    logic        w_run;
    logic [12:0] w_h13;
    logic [12:0] w_v13;
    logic        w_active;
    logic        w_hs;
    logic        w_vs;
    logic        w_consume;

    logic        r_disp_en;
    logic [1:0]  r_ctrl_b;
    logic [23:0] r_data;
    logic [11:0] r_hcount;
    logic [11:0] r_vcount;
    logic        r_frame_start;
    logic        r_underflow;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= PARK;
            r_h     <= 12'd0;
            r_v     <= 12'd0;
        end else begin
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        case (r_state)
            PARK: begin
                w_h_nxt = 12'd0;
                w_v_nxt = 12'd0;
                if (i_enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_h == H_LAST) begin
                    w_h_nxt = 12'd0;
                    if (r_v == V_LAST) begin
                        // Frame boundary: the only point where enable is honoured while running.
                        w_v_nxt = 12'd0;
                        if (!i_enable) begin
                            w_state_nxt = PARK;
                        end
                    end else begin
                        w_v_nxt = r_v + 12'd1;
                    end
                end else begin
                    w_h_nxt = r_h + 12'd1;
                end
            end
            default: begin
                w_state_nxt = PARK;
                w_h_nxt     = 12'd0;
                w_v_nxt     = 12'd0;
            end
        endcase
    end

    assign w_run     = (r_state == RUN);
    assign w_h13     = {1'b0, r_h};
    assign w_v13     = {1'b0, r_v};
    assign w_active  = w_run && (w_h13 < H_ACT) && (w_v13 < V_ACT);
    assign w_hs      = w_run && (w_h13 >= HS_START) && (w_h13 < HS_END);
    assign w_vs      = w_run && (w_v13 >= VS_START) && (w_v13 < VS_END);
    assign w_consume = w_active && i_pix_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_disp_en     <= 1'b0;
            r_ctrl_b      <= {~VS_POL, ~HS_POL};
            r_data        <= 24'd0;
            r_hcount      <= 12'd0;
            r_vcount      <= 12'd0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            // Active video keeps disp_en high even without a pixel; the raster never stalls.
            r_disp_en     <= w_active;
            r_ctrl_b      <= {w_vs ^ ~VS_POL, w_hs ^ ~HS_POL};
            r_data        <= w_consume ? i_pix_data : 24'd0;
            r_hcount      <= r_h;
            r_vcount      <= r_v;
            r_frame_start <= w_run && (r_h == 12'd0) && (r_v == 12'd0);
            if (w_active && !i_pix_valid) begin
                r_underflow <= 1'b1;
            end else if (i_underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign o_pix_ready   = w_active;
    assign o_disp_en     = r_disp_en;
    assign o_ctrl_b      = r_ctrl_b;
    assign o_ctrl_g      = 2'b00;
    assign o_ctrl_r      = 2'b00;
    assign o_data_r      = r_data[23:16];
    assign o_data_g      = r_data[15:8];
    assign o_data_b      = r_data[7:0];
    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_frame_start = r_frame_start;
    assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_tmds_video_timing_ctrl.sv
// tb/tb_tmds_video_timing_ctrl.sv - directed bench for tmds_video_timing_ctrl
module tb_tmds_video_timing_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_pix_valid;
    logic [23:0] i_pix_data;
    logic        i_underflow_clr;
    logic        o_pix_ready;
    logic        o_disp_en;
    logic [1:0]  o_ctrl_b;
    logic [1:0]  o_ctrl_g;
    logic [1:0]  o_ctrl_r;
    logic [7:0]  o_data_r;
    logic [7:0]  o_data_g;
    logic [7:0]  o_data_b;
    logic [11:0] o_hcount;
    logic [11:0] o_vcount;
    logic        o_frame_start;
    logic        o_underflow;

    int checks = 0;
    int errors = 0;
    int next_pix = 1;
    int consumes = 0;
    int disp_cnt = 0;
    bit exp_uf = 1'b0;

    tmds_video_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_enable(i_enable),
        .i_pix_valid(i_pix_valid),
        .i_pix_data(i_pix_data),
        .i_underflow_clr(i_underflow_clr),
        .o_pix_ready(o_pix_ready),
        .o_disp_en(o_disp_en),
        .o_ctrl_b(o_ctrl_b),
        .o_ctrl_g(o_ctrl_g),
        .o_ctrl_r(o_ctrl_r),
        .o_data_r(o_data_r),
        .o_data_g(o_data_g),
        .o_data_b(o_data_b),
        .o_hcount(o_hcount),
        .o_vcount(o_vcount),
        .o_frame_start(o_frame_start),
        .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [23:0] pix_of(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {b ^ 8'hA5, b + 8'h40, b};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".disp_en"}, 32'(o_disp_en), 32'd0);
        chk({tag, ".ctrl_b"}, 32'(o_ctrl_b), 32'd3);
        chk({tag, ".ctrl_gr"}, 32'({o_ctrl_g, o_ctrl_r}), 32'd0);
        chk({tag, ".data"}, 32'({o_data_r, o_data_g, o_data_b}), 32'd0);
        chk({tag, ".hcount"}, 32'(o_hcount), 32'd0);
        chk({tag, ".vcount"}, 32'(o_vcount), 32'd0);
        chk({tag, ".frame_start"}, 32'(o_frame_start), 32'd0);
        chk({tag, ".pix_ready"}, 32'(o_pix_ready), 32'd0);
    endtask

    // Present raster position p (8x6 geometry) for one cycle and check its outputs.
    task automatic step_pos(input int p, input bit valid);
        int h;
        int v;
        bit act;
        logic [23:0] exp_d;
        h = p % 8;
        v = p / 8;
        act = (h < 4) && (v < 3);
        i_pix_valid = valid;
        i_pix_data = pix_of(next_pix);
        chk($sformatf("pix_ready@%0d,%0d", h, v), 32'(o_pix_ready), 32'(act));
        exp_d = 24'd0;
        if (act && valid) begin
            exp_d = pix_of(next_pix);
            next_pix++;
            consumes++;
        end
        if (act && !valid) exp_uf = 1'b1;
        else if (i_underflow_clr) exp_uf = 1'b0;
        tick();
        if (o_disp_en) disp_cnt++;
        chk($sformatf("hcount@%0d,%0d", h, v), 32'(o_hcount), 32'(h));
        chk($sformatf("vcount@%0d,%0d", h, v), 32'(o_vcount), 32'(v));
        chk($sformatf("disp_en@%0d,%0d", h, v), 32'(o_disp_en), 32'(act));
        chk($sformatf("ctrl_b@%0d,%0d", h, v), 32'(o_ctrl_b),
            32'({~(v == 4), ~(h == 5 || h == 6)}));
        chk($sformatf("ctrl_gr@%0d,%0d", h, v), 32'({o_ctrl_g, o_ctrl_r}), 32'd0);
        chk($sformatf("data@%0d,%0d", h, v), 32'({o_data_r, o_data_g, o_data_b}), 32'(exp_d));
        chk($sformatf("frame_start@%0d,%0d", h, v), 32'(o_frame_start), 32'(p == 0));
        chk($sformatf("underflow@%0d,%0d", h, v), 32'(o_underflow), 32'(exp_uf));
    endtask

    initial begin
        i_reset = 1'b1;
        i_enable = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_data = 24'd0;
        i_underflow_clr = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        chk("reset.underflow", 32'(o_underflow), 32'd0);

        i_reset = 1'b0;
        tick();
        chk("park.pix_ready", 32'(o_pix_ready), 32'd0);
        chk("park.disp_en", 32'(o_disp_en), 32'd0);

        i_enable = 1'b1;
        tick();
        chk("first_run.frame_start_not_yet", 32'(o_frame_start), 32'd0);

        // Frame 1: continuous pixels; enable glitches low mid-frame without effect.
        for (int p = 0; p < 48; p++) begin
            i_enable = !(p >= 30 && p < 34);
            step_pos(p, 1'b1);
        end
        chk("frame1.consumes", 32'(consumes), 32'd12);
        chk("frame1.disp_cycles", 32'(disp_cnt), 32'd12);
        consumes = 0;
        disp_cnt = 0;

        // Frame 2: starts 48 cycles after frame 1; underflow at (2,1); enable dropped mid-frame.
        for (int p = 0; p < 48; p++) begin
            i_enable = (p < 20);
            step_pos(p, p != 10);
        end
        chk("frame2.consumes", 32'(consumes), 32'd11);
        chk("frame2.disp_cycles", 32'(disp_cnt), 32'd12);
        chk("parked.pix_ready", 32'(o_pix_ready), 32'd0);

        tick();
        chk_reset_outputs("parked");
        chk("parked.underflow_sticky", 32'(o_underflow), 32'd1);

        i_underflow_clr = 1'b1;
        tick();
        i_underflow_clr = 1'b0;
        exp_uf = 1'b0;
        chk("uf_clr.underflow", 32'(o_underflow), 32'd0);

        // Restart at (0,0) with a clear coinciding with a fresh underflow: set wins.
        i_enable = 1'b1;
        tick();
        i_underflow_clr = 1'b1;
        step_pos(0, 1'b0);
        i_underflow_clr = 1'b0;
        for (int p = 1; p < 19; p++) begin
            step_pos(p, 1'b1);
        end

        // The counters now sit at (3,2): reset aborts the frame.
        chk("pre_reset.pix_ready", 32'(o_pix_ready), 32'd1);
        i_reset = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        chk("midreset.underflow", 32'(o_underflow), 32'd0);
        i_reset = 1'b0;
        i_enable = 1'b0;
        tick();
        chk_reset_outputs("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
